// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode tags, flag bit positions and the queue entry layout.
package alu_pkg;

  localparam int ALU_OPW   = 4;
  localparam int ALU_WIDTH = 128;

  localparam logic [ALU_OPW-1:0] OP_ROL  = 4'd0;
  localparam logic [ALU_OPW-1:0] OP_ROR  = 4'd1;
  localparam logic [ALU_OPW-1:0] OP_MAX  = 4'd2;
  localparam logic [ALU_OPW-1:0] OP_MIN  = 4'd3;
  localparam logic [ALU_OPW-1:0] OP_NAND = 4'd4;
  localparam logic [ALU_OPW-1:0] OP_SLTU = 4'd5;
  localparam logic [ALU_OPW-1:0] OP_XOR  = 4'd6;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;

  // Entry layout for the default widths; the queue packs entries in this same order.
  typedef struct packed {
    logic [ALU_OPW-1:0]   opcode;
    logic [ALU_WIDTH-1:0] result;
    logic [2:0]           flags;
  } alu_entry_t;

endpackage

// File: rtl/alu_result_fifo_mem.sv
// Queue storage: DEPTH x EW register array, one write port, asynchronous head read.
module alu_result_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int EW    = 135,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [EW-1:0] rdata
);

  logic [EW-1:0] mem [DEPTH];

  // Contents are deliberately not reset; validity is tracked by the pointers outside.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_queue.sv
// Registered show-ahead result queue behind the 128-bit ALU, with sticky flags and stall counter.
module alu_result_queue
  import alu_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int DEPTH  = 4,
  parameter int OPW    = 4,
  parameter int STALLW = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPW-1:0]           in_opcode,
  input  logic [WIDTH-1:0]         in_result,
  input  logic                     in_carry,
  input  logic                     in_zero,
  input  logic                     in_ovf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPW-1:0]           out_opcode,
  output logic [WIDTH-1:0]         out_result,
  output logic [2:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic [2:0]               sticky_flags,
  input  logic                     clear_sticky,
  output logic [STALLW-1:0]        stall_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = OPW + WIDTH + 3;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready depends only on registered occupancy, never on out_ready, so a full
  // queue refuses a push even in a cycle where the head is being popped.

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [2:0]    in_flags;
  logic [EW-1:0] wr_entry, head_entry;
  logic          push, pop;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    in_flags         = '0;
    in_flags[FLAG_C] = in_carry;
    in_flags[FLAG_Z] = in_zero;
    in_flags[FLAG_V] = in_ovf;
  end

  assign wr_entry = {in_opcode, in_result, in_flags};

  alu_result_fifo_mem #(
    .DEPTH (DEPTH),
    .EW    (EW),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head_entry)
  );

  // Outputs read as zero while empty so unreset storage never leaks out.
  always_comb begin
    out_opcode = '0;
    out_result = '0;
    out_flags  = '0;
    if (out_valid) begin
      {out_opcode, out_result, out_flags} = head_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Clear takes priority over history but not over a same-cycle push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= '0;
    end else if (clear_sticky) begin
      sticky_flags <= push ? in_flags : 3'b000;
    end else if (push) begin
      sticky_flags <= sticky_flags | in_flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (in_valid && !in_ready && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue: reset, push/pop, fill/stall, wrap, sticky flags, async reset.
module tb_alu_result_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_opcode;
  logic [127:0] in_result;
  logic         in_carry, in_zero, in_ovf;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_opcode;
  logic [127:0] out_result;
  logic [2:0]   out_flags;
  logic [2:0]   count;
  logic [2:0]   sticky_flags;
  logic         clear_sticky;
  logic [7:0]   stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_result_queue #(
    .WIDTH(128), .DEPTH(4), .OPW(4), .STALLW(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_result    (in_result),
    .in_carry     (in_carry),
    .in_zero      (in_zero),
    .in_ovf       (in_ovf),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opcode   (out_opcode),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .count        (count),
    .sticky_flags (sticky_flags),
    .clear_sticky (clear_sticky),
    .stall_count  (stall_count)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [3:0] op, input logic [127:0] res,
                        input logic c, input logic z, input logic o);
    in_valid  = v;
    in_opcode = op;
    in_result = res;
    in_carry  = c;
    in_zero   = z;
    in_ovf    = o;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    clear_sticky = 1'b0;
    set_in(1'b0, 4'd0, 128'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset then idle
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_sticky", sticky_flags, 0);
    check("rst_stall", stall_count, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_opcode", out_opcode, 0);
    check("rst_out_flags", out_flags, 0);

    // Single push then pop
    set_in(1'b1, 4'd6, 128'hFF, 1'b0, 1'b0, 1'b0);
    step();
    set_in(1'b0, 4'd0, 128'd0, 1'b0, 1'b0, 1'b0);
    check("single_valid", out_valid, 1);
    check("single_result", out_result, 128'hFF);
    check("single_opcode", out_opcode, 6);
    check("single_count", count, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("single_pop_count", count, 0);
    check("single_pop_valid", out_valid, 0);

    // Fill and stall
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b1, 4'd2, 128'(i), 1'b0, 1'b0, 1'b0);
      step();
    end
    check("fill_count", count, 4);
    check("fill_in_ready", in_ready, 0);
    set_in(1'b1, 4'd2, 128'h99, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    set_in(1'b0, 4'd0, 128'd0, 1'b0, 1'b0, 1'b0);
    check("stall_count", stall_count, 3);
    check("stall_hold_count", count, 4);
    check("stall_head", out_result, 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_%0d", i), out_result, 128'(i));
      step();
    end
    out_ready = 1'b0;
    check("drain_count", count, 0);
    check("stall_after_drain", stall_count, 3);

    // Wrap-around with concurrent push and pop at count 2
    for (int i = 10; i <= 11; i++) begin
      set_in(1'b1, 4'd1, 128'(i), 1'b0, 1'b0, 1'b0);
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_in(1'b1, 4'd1, 128'(12 + k), 1'b0, 1'b0, 1'b0);
      check($sformatf("wrap_count_%0d", k), count, 2);
      check($sformatf("wrap_data_%0d", k), out_result, 128'(10 + k));
      step();
    end
    set_in(1'b0, 4'd0, 128'd0, 1'b0, 1'b0, 1'b0);
    check("wrap_tail_20", out_result, 20);
    step();
    check("wrap_tail_21", out_result, 21);
    step();
    out_ready = 1'b0;
    check("wrap_empty", count, 0);
    check("wrap_sticky_clean", sticky_flags, 0);

    // Sticky flags
    set_in(1'b1, 4'd3, 128'hA, 1'b0, 1'b1, 1'b0);
    step();
    set_in(1'b1, 4'd4, 128'hB, 1'b0, 1'b0, 1'b1);
    step();
    check("sticky_zv", sticky_flags, 3'b110);
    check("sticky_head_flags", out_flags, 3'b010);
    clear_sticky = 1'b1;
    set_in(1'b1, 4'd5, 128'hC, 1'b1, 1'b0, 1'b0);
    step();
    set_in(1'b0, 4'd0, 128'd0, 1'b0, 1'b0, 1'b0);
    check("sticky_clear_push", sticky_flags, 3'b001);
    step();
    clear_sticky = 1'b0;
    check("sticky_clear_only", sticky_flags, 3'b000);
    check("pre_reset_count", count, 3);

    // Async reset mid-stream, between edges
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_count", count, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    set_in(1'b1, 4'd3, 128'h1234, 1'b1, 1'b0, 1'b1);
    step();
    set_in(1'b0, 4'd0, 128'd0, 1'b0, 1'b0, 1'b0);
    check("post_rst_count", count, 1);
    check("post_rst_result", out_result, 128'h1234);
    check("post_rst_opcode", out_opcode, 3);
    check("post_rst_flags", out_flags, 3'b101);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_rst_empty", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
